// File: rtl/cga_vram_port.sv
// CPU-side ISA port into the CGA framebuffer RAM: buffers writes in a FIFO and issues RAM ops
// only in sequencer slots. Optional feature macro: CGA_BUS_WAIT_EN (ISA wait-state generation).
module cga_vram_port #(
  parameter logic [19:0] FRAMEBUFFER_ADDR = 20'hB8000,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter logic [3:0]  RAM_BANK         = 4'b0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] bus_a,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic        bus_aen,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  output logic        bus_rdy,
  input  logic        isa_op_enable,
  output logic [18:0] ram_a,
  output logic [7:0]  ram_wd,
  input  logic [7:0]  ram_rd,
  output logic        ram_we_l,
  output logic        ram_grant,
  output logic [2:0]  fifo_level,
  output logic        overflow
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_WAIT, RD_ISSUE, RD_CAPTURE} state_e;
  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } entry_t;

  // Bits [1:0] form the two-flop synchronizer; bit [2] is the previous synced value.
  logic [2:0] memr_sync_q, memw_sync_q;
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      memr_sync_q <= '1;
      memw_sync_q <= '1;
    end else begin
      memr_sync_q <= {memr_sync_q[1:0], bus_memr_l};
      memw_sync_q <= {memw_sync_q[1:0], bus_memw_l};
    end
  end

  logic   cs, rd_det, wr_det, slot;
  entry_t new_entry;
  assign cs        = (bus_a[19:15] == FRAMEBUFFER_ADDR[19:15]) & ~bus_aen;
  assign rd_det    = ~reset & cs & memr_sync_q[2] & ~memr_sync_q[1];
  assign wr_det    = ~reset & cs & memw_sync_q[2] & ~memw_sync_q[1];
  assign slot      = ~reset & isa_op_enable;
  assign new_entry = '{addr: bus_a[14:0], data: bus_d};

  // Write FIFO
  entry_t           fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  entry_t           head, push_entry;
  logic             push, pop, fifo_empty, fifo_full, room;

  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign room       = ~fifo_full | pop;
  assign fifo_level = (32'(count_q) > 7) ? 3'd7 : 3'(count_q);

  // NOTE: the storage array carries no reset; emptiness is tracked by the reset pointers/count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Read-side FSM
  state_e      state_q, state_d;
  logic        rd_req_q, rd_req_d, rd_busy, rd_accept, rd_go;
  logic [14:0] raddr_q;
  logic [7:0]  bus_out_q;

  assign rd_busy   = (state_q == RD_WAIT) | (state_q == RD_ISSUE) | (state_q == RD_CAPTURE);
  assign rd_accept = rd_det & ~rd_busy & ~rd_req_q;
  assign rd_go     = rd_req_q | rd_accept;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    rd_req_d  = rd_go;
    pop       = 1'b0;
    ram_grant = 1'b0;
    ram_we_l  = 1'b1;
    ram_a     = '0;
    ram_wd    = '0;
    unique case (state_q)
      IDLE, WR_ISSUE: begin
        state_d = IDLE;
        if (state_q == IDLE && slot && !fifo_empty) begin
          pop       = 1'b1;
          ram_grant = 1'b1;
          ram_we_l  = 1'b0;
          ram_a     = {RAM_BANK, head.addr};
          ram_wd    = head.data;
          state_d   = WR_ISSUE;
        end else if (rd_go) begin
          state_d  = RD_WAIT;
          rd_req_d = 1'b0;
        end
      end
      RD_WAIT: begin
        // Older writes drain first so the read observes them.
        if (slot && !fifo_empty) begin
          pop       = 1'b1;
          ram_grant = 1'b1;
          ram_we_l  = 1'b0;
          ram_a     = {RAM_BANK, head.addr};
          ram_wd    = head.data;
        end else if (fifo_empty) begin
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (slot) begin
          ram_grant = 1'b1;
          ram_a     = {RAM_BANK, raddr_q};
          state_d   = RD_CAPTURE;
        end
      end
      RD_CAPTURE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_req_q  <= 1'b0;
      raddr_q   <= '0;
      bus_out_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_req_q <= rd_req_d;
      if (rd_accept)                bus_out_q <= bus_out_q;
      if (rd_accept)                raddr_q   <= bus_a[14:0];
      if (state_q == RD_CAPTURE)    bus_out_q <= ram_rd;
    end
  end
  assign bus_out = bus_out_q;

`ifdef CGA_BUS_WAIT_EN
  // A write that finds the FIFO full parks here and stalls the host until it is pushed.
  logic   stage_valid_q, wr_stall;
  entry_t stage_q;

  always_comb begin
    push       = 1'b0;
    wr_stall   = 1'b0;
    push_entry = stage_q;
    if (stage_valid_q) begin
      push = room;
    end else if (wr_det) begin
      push_entry = new_entry;
      push       = room;
      wr_stall   = ~room;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
    end else if (wr_stall) begin
      stage_valid_q <= 1'b1;
      stage_q       <= new_entry;
    end else if (push) begin
      stage_valid_q <= 1'b0;
    end
  end

  assign overflow = 1'b0;
  assign bus_rdy  = reset | ~(rd_accept | rd_req_q | rd_busy | wr_stall | stage_valid_q);
  assign bus_dir  = ~reset & cs & ~bus_memr_l & ~(rd_accept | rd_req_q | rd_busy);
`else
  logic overflow_q;

  assign push       = wr_det & room;
  assign push_entry = new_entry;

  always_ff @(posedge clk) begin
    if (reset)                overflow_q <= 1'b0;
    else if (wr_det && !room) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;
  assign bus_rdy  = 1'b1;
  assign bus_dir  = ~reset & cs & ~bus_memr_l;
`endif

endmodule

// File: doc/cga_vram_port.md
Name: cga_vram_port

Overview:
- CPU-side write/read port into the CGA framebuffer RAM; the display pipeline is the reader of that RAM.
- Decodes ISA memory cycles in the B8000 window and buffers writes in a small FIFO.
- Issues buffered writes and single reads to RAM only in sequencer-granted isa_op_enable slots, so display fetches are never disturbed.
- Returns read data on the ISA bus, with optional wait-state generation.

Parameters:
- FRAMEBUFFER_ADDR, 20'hB8000, base of the 32 KB decode window; bus_a[19:15] is compared against FRAMEBUFFER_ADDR[19:15].
- FIFO_DEPTH, 4, write FIFO entries; must be a power of 2, from 2 to 16.
- RAM_BANK, 4'b0001, constant ram_a[18:15] placed above the 15-bit offset.

Ports:
- clk  in  1  system clock, same as the display sequencer.
- reset  in  1  synchronous, active-high.
- bus_a  in  20  ISA address.
- bus_memr_l  in  1  ISA memory read strobe, active low, asynchronous.
- bus_memw_l  in  1  ISA memory write strobe, active low, asynchronous.
- bus_aen  in  1  DMA address enable; cycle ignored when 1.
- bus_d  in  8  ISA write data.
- bus_out  out  8  read data to the ISA bus.
- bus_dir  out  1  1 = drive bus_out (CPU read of this window in progress).
- bus_rdy  out  1  ISA ready; 0 inserts wait states.
- isa_op_enable  in  1  one-clk slot pulse from the sequencer; RAM is free this cycle.
- ram_a  out  19  RAM address, {RAM_BANK, offset[14:0]}.
- ram_wd  out  8  RAM write data.
- ram_rd  in  8  RAM read data, valid the cycle after the slot.
- ram_we_l  out  1  RAM write enable, active low.
- ram_grant  out  1  1 = this block owns ram_a/ram_we_l this cycle (mux select for the top level).
- fifo_level  out  3  current FIFO occupancy, for debug.
- overflow  out  1  sticky; a write was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - bus_out=0, bus_dir=0, bus_rdy=1.
  - ram_we_l=1, ram_grant=0, ram_a=0, ram_wd=0.
  - fifo_level=0, overflow=0, FSM=IDLE.
  - Sync flops are set to 1 (inactive).
  - Reset mid-operation aborts any pending read and discards all FIFO contents.
- Chip select: cs = (bus_a[19:15]==FRAMEBUFFER_ADDR[19:15]) & ~bus_aen.
- Strobe sync:
  - bus_memr_l and bus_memw_l pass through 2-flop synchronizers.
  - A cycle starts on a synced 1->0 edge with cs true at that clk.
  - bus_a[14:0] and bus_d are captured at that same clk.
- Write:
  - Push {addr,data} into the FIFO on the detect clk.
  - If the FIFO is full, behaviour is set by CGA_BUS_WAIT_EN.
  - fifo_level updates the cycle after push/pop; a simultaneous push and pop leaves it unchanged.
- FSM states: IDLE, WR_ISSUE, RD_WAIT, RD_ISSUE, RD_CAPTURE.
  - IDLE:
    - On isa_op_enable with FIFO non-empty, assert ram_grant=1, ram_we_l=0, ram_a={RAM_BANK,head.addr}, ram_wd=head.data combinationally in that cycle, and pop the FIFO.
    - WR_ISSUE is a one-cycle label for that slot; it returns to IDLE.
    - A pending read detect moves to RD_WAIT.
  - RD_WAIT: keep draining FIFO writes in slots (read-after-write ordering); go to RD_ISSUE once the FIFO is empty.
  - RD_ISSUE: on the next isa_op_enable, assert ram_grant=1, ram_we_l=1, ram_a={RAM_BANK,raddr}, then go to RD_CAPTURE.
  - RD_CAPTURE: latch bus_out<=ram_rd and go to IDLE.
  - bus_out holds its value until the next read capture.
- Read data path:
  - bus_dir = cs & ~bus_memr_l (raw strobe), gated with ~bus_rdy-pending so data is only driven once valid.
  - Exception: without the macro, bus_dir = cs & ~bus_memr_l.
- Slot conflicts:
  - One RAM op per isa_op_enable pulse.
  - A write detect and a slot in the same clk is legal: the push and the pop of an older entry both happen.
  - If the FIFO is empty, a write pushed on a slot clk waits for the next slot.
  - A read detect while a read is still pending is ignored (ISA cannot overlap).
- Outside slots: ram_grant=0 and ram_we_l=1 always.

Optional Feature:
- Macro: CGA_BUS_WAIT_EN.
- Defined:
  - bus_rdy is driven low from the clk a read is detected until the clk after RD_CAPTURE.
  - bus_rdy is driven low while a write detect finds the FIFO full; the write is held in a staging register and pushed on the first free slot, then bus_rdy returns to 1.
  - overflow never sets.
- Undefined:
  - bus_rdy tied to 1.
  - A write to a full FIFO is dropped and overflow is set (sticky until reset).
  - Read data is valid only if the host holds memr for at least FIFO_DEPTH+1 slot periods plus 4 clk.

Test Plan:
- Write B8000=0x5A, next slot -> ram_grant=1, ram_we_l=0, ram_a=19'h08000, ram_wd=0x5A for exactly 1 clk; fifo_level back to 0.
- Write B9234=0x11 then read B9234 before the write drains -> the write issues first, the read issues on the following slot, bus_out=0x11, bus_dir high during memr.
- Five writes with no slots (FIFO_DEPTH=4), macro undefined -> fifo_level=4, overflow=1, fifth write lost; the four entries drain in order.
- Same as above with CGA_BUS_WAIT_EN -> bus_rdy=0 on the fifth write until the first slot frees an entry, then all 5 reach RAM and overflow stays 0.
- Write to C0000, or any write with bus_aen=1 -> no push, no ram_grant, fifo_level=0.
- Assert reset with 3 queued entries and a pending read -> next cycle fifo_level=0, bus_rdy=1, bus_out=0, no further ram_grant.
